// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer: a bus slave holding TARGET/STEP/PERIOD that ramps a PWM
// threshold toward TARGET by issuing timed byte writes over a master port.
module pwm_fade_sequencer #(
  parameter logic [31:0] PWM_ADDR  = 32'h0000_0000,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        busy
);

  localparam int unsigned DW = DIV_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WAIT} state_t;

  state_t          state, state_d;
  logic [7:0]      target, step, current, current_d, step_nxt;
  logic [DW-1:0]   period, cnt, cnt_d, period_m1;
  logic            done, done_d, stop_pend, stop_pend_d;
  logic            busy_d, m_valid_d;
  logic            accept, wr, start_c, stop_c, ack_c;
  logic [2:0]      sel;
  logic [31:0]     wmask, rd_val;
  logic [7:0]      s_eff;
  logic [8:0]      sum9, diff9;
  logic            unused;

  assign accept  = valid & ~ready;
  assign wr      = accept & (wstrb != 4'b0000);
  assign sel     = addr[4:2];
  assign wmask   = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign start_c = wr & (sel == 3'd0) & wstrb[0] & wdata[0];
  assign stop_c  = wr & (sel == 3'd0) & wstrb[0] & wdata[1];
  assign ack_c   = m_valid & m_ready;
  assign unused  = ^{addr[31:5], addr[1:0]};

  assign m_addr  = PWM_ADDR;
  assign m_wdata = {24'b0, current};

  // Register read mux
  always_comb begin
    rd_val = 32'b0;
    case (sel)
      3'd0:    rd_val = {22'b0, done, busy, 8'b0};
      3'd1:    rd_val = {24'b0, target};
      3'd2:    rd_val = {24'b0, step};
      3'd3:    rd_val = 32'(period);
      3'd4:    rd_val = {24'b0, current};
      default: rd_val = 32'b0;
    endcase
  end

  // Slave handshake and configuration registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready  <= 1'b0;
      rdata  <= 32'b0;
      target <= 8'b0;
      step   <= 8'b0;
      period <= '0;
    end else begin
      ready <= accept;
      rdata <= accept ? rd_val : 32'b0;
      if (wr) begin
        case (sel)
          3'd1: if (wstrb[0]) target <= wdata[7:0];
          3'd2: if (wstrb[0]) step <= wdata[7:0];
          3'd3: period <= (period & ~wmask[DW-1:0]) | (wdata[DW-1:0] & wmask[DW-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Next duty: clamp at TARGET using 9-bit arithmetic so neither direction wraps
  always_comb begin
    s_eff = (step == 8'd0) ? 8'd1 : step;
    sum9  = {1'b0, current} + {1'b0, s_eff};
    diff9 = {1'b0, current} - {1'b0, s_eff};
    if (current < target)
      step_nxt = (sum9 > {1'b0, target}) ? target : sum9[7:0];
    else if (current > target)
      step_nxt = (diff9[8] || (diff9[7:0] < target)) ? target : diff9[7:0];
    else
      step_nxt = current;
  end

  assign period_m1 = (period == '0) ? '0 : period - DW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start_c) state_d = ST_WRITE;
      ST_WRITE: if (m_ready) begin
                  if (stop_c || stop_pend || (current == target)) state_d = ST_IDLE;
                  else                                          state_d = ST_WAIT;
                end
      ST_WAIT:  if (stop_c)           state_d = ST_IDLE;
                else if (cnt == '0)   state_d = ST_WRITE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    m_valid_d   = (state_d == ST_WRITE);
    done_d      = done;
    current_d   = current;
    cnt_d       = cnt;
    stop_pend_d = 1'b0;
    case (state)
      ST_IDLE:  if (start_c) done_d = 1'b0;
      ST_WRITE: begin
        stop_pend_d = ~m_ready & (stop_pend | stop_c);
        if (m_ready) begin
          done_d = ~(stop_c | stop_pend) & (current == target);
          cnt_d  = period_m1;
        end
      end
      ST_WAIT: begin
        if (stop_c)            done_d = 1'b0;
        else if (cnt == '0)    current_d = step_nxt;
        else                   cnt_d = cnt - DW'(1);
      end
      default: ;
    endcase
  end

  // Registered FSM outputs and datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      m_valid   <= 1'b0;
      m_wstrb   <= 4'b0;
      done      <= 1'b0;
      current   <= 8'b0;
      cnt       <= '0;
      stop_pend <= 1'b0;
    end else begin
      busy      <= busy_d;
      m_valid   <= m_valid_d;
      m_wstrb   <= m_valid_d ? 4'b0001 : 4'b0000;
      done      <= done_d;
      current   <= current_d;
      cnt       <= cnt_d;
      stop_pend <= stop_pend_d;
    end
  end

  logic unused_ack;
  assign unused_ack = ack_c;

endmodule
